// File: rtl/rs_syndrome_unit.sv
// rs_syndrome_unit: streaming Reed-Solomon syndrome calculator over GF(2^10).
// Folds each received symbol into S_j = r(alpha^j), j=0..R-1, by Horner rule.
// Ports:
//   clk_i, rst_i            clock, async active-high reset
//   in_valid_i/in_ready_o   symbol handshake; in_sop_i/in_eop_i frame marks
//   in_sym_i                received symbol, highest degree first
//   synd_o[0:R-1]           syndromes, valid while synd_valid_o=1
//   synd_valid_o/synd_ready_i  result handshake to the key-equation solver
//   err_free_o              all syndromes zero
//   len_err_o               frame length differed from N
module rs_syndrome_unit #(
  parameter int W = 10,
  parameter int R = 22,
  parameter int N = 544
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic         in_sop_i,
  input  logic         in_eop_i,
  input  logic [W-1:0] in_sym_i,
  output logic [W-1:0] synd_o [0:R-1],
  output logic         synd_valid_o,
  input  logic         synd_ready_i,
  output logic         err_free_o,
  output logic         len_err_o
);

  localparam int            CW    = 10;
  localparam logic [CW-1:0] C_MAX = '1;
  localparam logic [CW-1:0] C_N   = CW'(N);
  // Reduction term of x^10 = x^3 + 1.
  localparam logic [W-1:0]  P     = W'(9);

  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [W-1:0]  r_synd     [0:R-1];
  logic [W-1:0]  w_horner   [0:R-1];
  logic [W-1:0]  w_synd_nxt [0:R-1];
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          r_err_free;
  logic          r_len_err;
  logic          w_accept;
  logic          w_load;
  logic          w_upd;
  logic          w_done;
  logic          w_zero;

  function automatic logic [W-1:0] f_xtime(
    input logic [W-1:0] a
  );
    return {a[W-2:0], 1'b0} ^ (a[W-1] ? P : '0);
  endfunction

  // Multiply by the fixed constant alpha^e; e is
  // elaboration-time, so this folds to an XOR net.
  function automatic logic [W-1:0] f_mul_apow(
    input logic [W-1:0] a,
    input int           e
  );
    logic [W-1:0] v;
    v = a;
    for (int k = 0; k < e; k++) v = f_xtime(v);
    return v;
  endfunction

  generate
    for (genvar j = 0; j < R; j++) begin : g_s
      assign w_horner[j] =
        f_mul_apow(r_synd[j], j) ^ in_sym_i;
      assign w_synd_nxt[j] =
        w_load ? in_sym_i : w_horner[j];
      assign synd_o[j] = r_synd[j];
    end
  endgenerate

  always_comb begin
    w_zero = 1'b1;
    for (int j = 0; j < R; j++)
      if (w_synd_nxt[j] != '0) w_zero = 1'b0;
  end

  assign in_ready_o   = !rst_i && (r_state != HOLD);
  assign w_accept     = in_valid_i && in_ready_o;
  assign synd_valid_o = (r_state == HOLD);
  assign err_free_o   = r_err_free;
  assign len_err_o    = r_len_err;

  // sop always restarts a frame, so a load also
  // resets the count; otherwise count saturates.
  assign w_cnt_nxt =
    w_load            ? CW'(1) :
    (r_cnt == C_MAX)  ? C_MAX  :
                        r_cnt + 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_upd       = 1'b0;
    w_done      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_accept && in_sop_i) begin
          w_load      = 1'b1;
          w_upd       = 1'b1;
          w_done      = in_eop_i;
          w_state_nxt = in_eop_i ? HOLD : ACC;
        end
      end
      ACC: begin
        if (w_accept) begin
          w_load      = in_sop_i;
          w_upd       = 1'b1;
          w_done      = in_eop_i;
          w_state_nxt = in_eop_i ? HOLD : ACC;
        end
      end
      HOLD: begin
        if (synd_ready_i) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_err_free <= 1'b0;
      r_len_err  <= 1'b0;
      for (int j = 0; j < R; j++) r_synd[j] <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_upd) begin
        r_cnt <= w_cnt_nxt;
        for (int j = 0; j < R; j++)
          r_synd[j] <= w_synd_nxt[j];
      end
      if (w_done) begin
        r_err_free <= w_zero;
        r_len_err  <= (w_cnt_nxt != C_N);
      end else if (r_state == HOLD && synd_ready_i) begin
        r_err_free <= 1'b0;
        r_len_err  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rs_syndrome_unit.sv
// tb_rs_syndrome_unit: table-driven frames with a scoreboard queue,
// plus hand sequences for back-pressure and mid-frame reset.
module tb_rs_syndrome_unit;

  localparam int W = 10;
  localparam int R = 22;
  localparam int N = 544;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic         in_valid_i = 1'b0;
  logic         in_sop_i = 1'b0;
  logic         in_eop_i = 1'b0;
  logic [W-1:0] in_sym_i = '0;
  logic         synd_ready_i = 1'b1;
  logic         in_ready_o;
  logic [W-1:0] synd_o [0:R-1];
  logic         synd_valid_o;
  logic         err_free_o;
  logic         len_err_o;

  int total = 0;
  int bad   = 0;
  int n_out = 0;

  typedef struct {
    logic [R-1:0][W-1:0] s;
    logic                ef;
    logic                le;
  } exp_t;

  typedef struct {
    int           junk;
    int           abrt;
    int           len;
    int           p0;
    logic [W-1:0] e0;
    int           p1;
    logic [W-1:0] e1;
    logic         ef;
    logic         le;
  } vec_t;

  exp_t                q[$];
  vec_t                tbl[11];
  logic [R-1:0][W-1:0] last_s;

  rs_syndrome_unit #(.W(W), .R(R), .N(N)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .in_sop_i     (in_sop_i),
    .in_eop_i     (in_eop_i),
    .in_sym_i     (in_sym_i),
    .synd_o       (synd_o),
    .synd_valid_o (synd_valid_o),
    .synd_ready_i (synd_ready_i),
    .err_free_o   (err_free_o),
    .len_err_o    (len_err_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [W-1:0] gf_mul(
    input logic [W-1:0] a,
    input logic [W-1:0] b
  );
    logic [W-1:0] r;
    logic [W-1:0] x;
    r = '0;
    x = a;
    for (int i = 0; i < W; i++) begin
      if (b[i]) r = r ^ x;
      x = {x[W-2:0], 1'b0} ^ (x[W-1] ? 10'h009 : 10'h000);
    end
    return r;
  endfunction

  function automatic logic [W-1:0] gf_pow(
    input logic [W-1:0] a,
    input int           e
  );
    logic [W-1:0] r;
    r = 10'h001;
    for (int i = 0; i < e; i++) r = gf_mul(r, a);
    return r;
  endfunction

  // Direct evaluation: S_j = sum e * (alpha^j)^p.
  function automatic exp_t model(input vec_t v);
    exp_t x;
    logic [W-1:0] aj;
    for (int j = 0; j < R; j++) begin
      x.s[j] = '0;
      aj = gf_pow(10'h002, j);
      if (v.p0 >= 0)
        x.s[j] = x.s[j] ^ gf_mul(v.e0, gf_pow(aj, v.p0));
      if (v.p1 >= 0)
        x.s[j] = x.s[j] ^ gf_mul(v.e1, gf_pow(aj, v.p1));
    end
    x.ef = v.ef;
    x.le = v.le;
    return x;
  endfunction

  task automatic chk1(input string nm, input logic a, input logic e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0b want %0b", nm, a, e);
    end
  endtask

  task automatic chkw(input string nm,
                      input logic [W-1:0] a,
                      input logic [W-1:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, a, e);
    end
  endtask

  task automatic chkv(input string nm,
                      input logic [R*W-1:0] a,
                      input logic [R*W-1:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, a, e);
    end
  endtask

  task automatic chki(input string nm, input int a, input int e);
    total++;
    if (a != e) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, a, e);
    end
  endtask

  // Result monitor: pops the scoreboard on each accepted result.
  always begin
    exp_t                e;
    logic [R-1:0][W-1:0] a;
    @(negedge clk_i);
    #1;
    if (!rst_i && synd_valid_o && synd_ready_i) begin
      for (int j = 0; j < R; j++) a[j] = synd_o[j];
      last_s = a;
      n_out++;
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out: got result want none");
      end else begin
        e = q.pop_front();
        chkv("synd", a, e.s);
        chk1("err_free", err_free_o, e.ef);
        chk1("len_err", len_err_o, e.le);
      end
    end
  end

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic drive_beat(input logic [W-1:0] s,
                            input logic sop,
                            input logic eop);
    int t;
    t = 0;
    in_valid_i = 1'b1;
    in_sym_i   = s;
    in_sop_i   = sop;
    in_eop_i   = eop;
    while (!in_ready_o && t < 100) begin
      @(negedge clk_i);
      t++;
    end
    if (t >= 100) chk1("beat_ready_timeout", in_ready_o, 1'b1);
    @(negedge clk_i);
    in_valid_i = 1'b0;
    in_sop_i   = 1'b0;
    in_eop_i   = 1'b0;
  endtask

  task automatic send_frame(input vec_t v);
    int           deg;
    logic [W-1:0] s;
    for (int i = 0; i < v.junk; i++)
      drive_beat(W'($urandom), 1'b0, 1'b0);
    for (int b = 0; b < v.abrt; b++)
      drive_beat(W'($urandom), b == 0, 1'b0);
    q.push_back(model(v));
    for (int b = 0; b < v.len; b++) begin
      deg = v.len - 1 - b;
      s = '0;
      if (deg == v.p0) s = s ^ v.e0;
      if (deg == v.p1) s = s ^ v.e1;
      drive_beat(s, b == 0, b == v.len - 1);
    end
  endtask

  task automatic wait_out(input int target);
    int t;
    t = 0;
    while (n_out < target && t < 200) begin
      @(negedge clk_i);
      t++;
    end
    chk1("out_arrived", n_out >= target, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t         sv;
    logic [W-1:0] c3;
    logic         cef;
    logic         cle;

    tbl[0]  = '{0, 0, N, -1, 10'h000, -1, 10'h000, 1'b1, 1'b0};
    tbl[1]  = '{0, 0, N, 0, 10'h001, -1, 10'h000, 1'b0, 1'b0};
    tbl[2]  = '{0, 0, N, 1, 10'h001, -1, 10'h000, 1'b0, 1'b0};
    tbl[3]  = '{3, 0, N, 543, 10'h3ff, 100, 10'h2a5, 1'b0, 1'b0};
    tbl[4]  = '{0, 0, 10, -1, 10'h000, -1, 10'h000, 1'b1, 1'b1};
    tbl[5]  = '{0, 0, 600, -1, 10'h000, -1, 10'h000, 1'b1, 1'b1};
    tbl[6]  = '{0, 0, 1, 0, 10'h155, -1, 10'h000, 1'b0, 1'b1};
    tbl[7]  = '{0, 50, N, 200, 10'h0f0, -1, 10'h000, 1'b0, 1'b0};
    tbl[8]  = '{2, 1, N, 7, 10'h003, -1, 10'h000, 1'b0, 1'b0};
    tbl[9]  = '{0, 0, N + 1024, -1, 10'h000, -1, 10'h000, 1'b1, 1'b1};
    tbl[10] = '{0, 0, N - 1, -1, 10'h000, -1, 10'h000, 1'b1, 1'b1};

    #12;
    chk1("rst_ready", in_ready_o, 1'b0);
    chk1("rst_valid", synd_valid_o, 1'b0);
    chk1("rst_ef", err_free_o, 1'b0);
    chk1("rst_le", len_err_o, 1'b0);
    chkw("rst_s0", synd_o[0], 10'h000);
    chkw("rst_slast", synd_o[R-1], 10'h000);
    @(negedge clk_i);
    #2 rst_i = 1'b0;
    @(negedge clk_i);
    chk1("post_rst_ready", in_ready_o, 1'b1);

    for (int i = 0; i < 11; i++) send_frame(tbl[i]);
    wait_out(11);

    sv = '{0, 0, N, 1, 10'h001, -1, 10'h000, 1'b0, 1'b0};
    send_frame(sv);
    wait_out(12);
    chkw("alpha_s0", last_s[0], 10'h001);
    chkw("alpha_s1", last_s[1], 10'h002);
    chkw("alpha_s2", last_s[2], 10'h004);
    chkw("alpha_s10", last_s[10], 10'h009);

    synd_ready_i = 1'b0;
    sv = '{0, 0, N, 5, 10'h1ab, -1, 10'h000, 1'b0, 1'b0};
    send_frame(sv);
    in_valid_i = 1'b1;
    in_sop_i   = 1'b1;
    in_sym_i   = 10'h005;
    c3  = synd_o[3];
    cef = err_free_o;
    cle = len_err_o;
    for (int i = 0; i < 20; i++) begin
      chk1("stall_valid", synd_valid_o, 1'b1);
      chk1("stall_ready", in_ready_o, 1'b0);
      chkw("stall_s3", synd_o[3], c3);
      chk1("stall_ef", err_free_o, cef);
      chk1("stall_le", len_err_o, cle);
      @(negedge clk_i);
    end
    synd_ready_i = 1'b1;
    in_valid_i   = 1'b0;
    in_sop_i     = 1'b0;
    @(negedge clk_i);
    chk1("release_ready", in_ready_o, 1'b1);
    chk1("release_valid", synd_valid_o, 1'b0);
    chki("stall_outputs", n_out, 13);

    for (int b = 0; b < 300; b++)
      drive_beat(W'($urandom), b == 0, 1'b0);
    #2 rst_i = 1'b1;
    #1;
    chk1("midrst_ready", in_ready_o, 1'b0);
    chk1("midrst_valid", synd_valid_o, 1'b0);
    chkw("midrst_s1", synd_o[1], 10'h000);
    @(negedge clk_i);
    #2 rst_i = 1'b0;
    @(negedge clk_i);
    chk1("midrst_ready_after", in_ready_o, 1'b1);
    send_frame(tbl[0]);
    wait_out(14);
    repeat (10) @(negedge clk_i);
    chki("final_outputs", n_out, 14);
    chki("sb_empty", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rs_syndrome_unit.md
RS_SYNDROME_UNIT -- requirements
Module: rs_syndrome_unit

Interface
REQ-001 SHALL have parameter W, default 10: symbol width, GF(2^10).
REQ-002 SHALL have parameter R, default 22: parity symbols, equal to the number of syndromes.
REQ-003 SHALL have parameter N, default 544: codeword length in symbols.
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-005 SHALL have port rst_i, input, 1 bit: reset, asynchronous, active-high.
REQ-006 SHALL have port in_valid_i, input, 1 bit: input symbol valid.
REQ-007 SHALL have port in_ready_o, output, 1 bit: unit accepts a symbol.
REQ-008 SHALL have port in_sop_i, input, 1 bit: first symbol of frame.
REQ-009 SHALL have port in_eop_i, input, 1 bit: last symbol of frame.
REQ-010 SHALL have port in_sym_i, input, W bits: received symbol r_k, highest degree (k=N-1) first.
REQ-011 SHALL have port synd_o, output, array [0:R-1] of W bits: syndromes S_0..S_{R-1}.
REQ-012 SHALL have port synd_valid_o, output, 1 bit: syndromes and flags valid.
REQ-013 SHALL have port synd_ready_i, input, 1 bit: downstream (key-equation solver) accepts.
REQ-014 SHALL have port err_free_o, output, 1 bit: all syndromes zero.
REQ-015 SHALL have port len_err_o, output, 1 bit: frame length not equal to N.

Function
REQ-016 SHALL compute GF arithmetic with field polynomial x^10+x^3+1 and alpha = 10'h002.
REQ-017 SHALL compute S_j = r(alpha^j) for j=0..R-1 by Horner: S_j <= (S_j * alpha^j) XOR in_sym_i on every accepted beat.
- Constant multipliers only.
- No general GF multiplier.
REQ-018 SHALL accept a beat only when in_valid_i and in_ready_o are both 1.
REQ-019 SHALL implement FSM states IDLE, ACC, HOLD.
REQ-020 In IDLE, SHALL drive in_ready_o=1 and handle accepted beats as follows.
- Beat without in_sop_i: discarded.
- Beat with in_sop_i: S_j loaded with in_sym_i for all j, count=1, next state ACC.
REQ-021 In ACC, SHALL drive in_ready_o=1; each accepted beat applies Horner and increments count, saturating at 1023.
REQ-022 On an accepted beat with in_eop_i (in IDLE-with-sop or ACC), SHALL update the syndromes, latch len_err_o = (final count != N), and move to HOLD.
REQ-023 An accepted in_sop_i beat in ACC SHALL abort the current frame and restart accumulation as in REQ-020, with no output for the aborted frame.
REQ-024 A beat carrying both in_sop_i and in_eop_i SHALL yield a one-symbol frame with len_err_o=1.
REQ-025 In HOLD, SHALL drive in_ready_o=0 and synd_valid_o=1, with synd_o, err_free_o and len_err_o stable.
REQ-026 In HOLD with synd_ready_i=1, SHALL leave HOLD and go to IDLE on the next edge.
REQ-027 SHALL assert synd_valid_o in the cycle after the eop beat is accepted (latency 1 cycle).
REQ-028 SHALL sustain back-to-back frames with one bubble cycle: the HOLD cycle while synd_ready_i=1.
REQ-029 err_free_o SHALL equal the NOR of all synd_o bits, registered with synd_valid_o.
REQ-030 synd_o SHALL hold its last value outside HOLD and SHALL NOT be relied upon when synd_valid_o=0.

Reset
REQ-031 On rst_i=1, asynchronously and at any time including mid-frame, SHALL force the following, discarding any partial frame.
- State IDLE, count 0.
- All synd_o = 0.
- synd_valid_o=0, err_free_o=0, len_err_o=0.
- in_ready_o=0 while rst_i=1.
REQ-032 After rst_i deasserts, SHALL assert in_ready_o=1 in the first cycle.

Verification
REQ-033 Scenario: all-zero frame, 544 beats, sop on first and eop on last, synd_ready_i=1 -> one cycle after eop: synd_valid_o=1, all S_j=0, err_free_o=1, len_err_o=0.
REQ-034 Scenario: zero frame with last symbol = 10'h001 (error at position 0) -> all S_j=10'h001, err_free_o=0, len_err_o=0.
REQ-035 Scenario: zero frame with second-to-last symbol = 10'h001 -> S_j=alpha^j, i.e. S_0=10'h001, S_1=10'h002, S_2=10'h004, S_10=10'h009.
REQ-036 Scenario: sop at beat 1, eop at beat 10 -> len_err_o=1, synd_valid_o=1; separately, 600 beats before eop -> len_err_o=1.
REQ-037 Scenario: synd_ready_i=0 for 20 cycles after a frame -> synd_valid_o held, outputs stable, in_ready_o=0 with in_valid_i=1 and no beat consumed; releasing synd_ready_i gives in_ready_o=1 next cycle.
REQ-038 Scenario: rst_i pulsed at beat 300 of a frame, then a clean zero frame -> exactly one synd_valid_o pulse, err_free_o=1, no output for the aborted frame.
